// File: rtl/radix2_pkg.sv
// Shared definitions for the radix-2 arithmetic unit (multiplier and divider).
package radix2_pkg;

    // Default operand width for the arithmetic unit.
    localparam int unsigned DEF_WIDTH = 8;

    // Booth recoding of {Q[0], q_m1}; 2'b00 and 2'b11 leave A unchanged.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Sequencer states shared by the multiplier and the divider.
    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_t;

endpackage

// File: rtl/radix2_mul_if.sv
// Issue/result handshake bundle of the radix-2 multiplier.
interface radix2_mul_if
    import radix2_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic                   sign;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   opn_valid;
    logic                   opn_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [2*WIDTH-1:0]     result;

    // Producer/consumer side.
    modport master (
        output sign,
        output multiplicand,
        output multiplier,
        output opn_valid,
        output res_ready,
        input  opn_ready,
        input  res_valid,
        input  result
    );

    // Multiplier side.
    modport slave (
        input  sign,
        input  multiplicand,
        input  multiplier,
        input  opn_valid,
        input  res_ready,
        output opn_ready,
        output res_valid,
        output result
    );

endinterface

// File: rtl/radix2_mul_booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M, then arithmetic right shift.
module booth_step
    import radix2_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH+1:0] a,
    input  logic [WIDTH:0]   q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH+1:0] a_nxt,
    output logic [WIDTH:0]   q_nxt,
    output logic             q_m1_nxt
);

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;

    // Recode the Booth pair, update A, then shift {A, Q, q_m1} right keeping A's sign.
    always_comb begin
        m_ext = {m[WIDTH], m};
        sum   = a;
        case ({q[0], q_m1})
            BOOTH_ADD: sum = a + m_ext;
            BOOTH_SUB: sum = a - m_ext;
            default:   sum = a;
        endcase
        a_nxt    = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_nxt    = {sum[0], q[WIDTH:1]};
        q_m1_nxt = q[0];
    end

endmodule

// File: rtl/radix2_mul.sv
// Sequential radix-2 Booth multiplier, one step per clock, with valid/ready on both sides.
module radix2_mul
    import radix2_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    radix2_mul_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    // Step index of the final (WIDTH+1-th) Booth step.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

    state_t               state;
    logic [WIDTH:0]       m;
    logic [WIDTH:0]       q;
    logic [WIDTH+1:0]     a;
    logic                 q_m1;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   result_r;
    logic                 res_valid_r;
    logic                 opn_ready_r;

    logic [WIDTH:0]       mcand_ext;
    logic [WIDTH:0]       mplier_ext;
    logic [WIDTH+1:0]     a_nxt;
    logic [WIDTH:0]       q_nxt;
    logic                 q_m1_nxt;

    // Widen operands by one bit so unsigned values stay positive under signed Booth recoding.
    always_comb begin
        mcand_ext  = {bus.sign & bus.multiplicand[WIDTH-1], bus.multiplicand};
        mplier_ext = {bus.sign & bus.multiplier[WIDTH-1], bus.multiplier};
    end

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a        (a),
        .q        (q),
        .q_m1     (q_m1),
        .m        (m),
        .a_nxt    (a_nxt),
        .q_nxt    (q_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    // Sequencer: accept, WIDTH+1 Booth steps, then hold the product until it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            m           <= '0;
            q           <= '0;
            a           <= '0;
            q_m1        <= 1'b0;
            cnt         <= '0;
            result_r    <= '0;
            res_valid_r <= 1'b0;
            opn_ready_r <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.opn_valid) begin
                        m           <= mcand_ext;
                        q           <= mplier_ext;
                        a           <= '0;
                        q_m1        <= 1'b0;
                        cnt         <= '0;
                        opn_ready_r <= 1'b0;
                        state       <= StCalc;
                    end
                end
                StCalc: begin
                    a    <= a_nxt;
                    q    <= q_nxt;
                    q_m1 <= q_m1_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        // Product is the low 2*WIDTH bits of {A, Q} after the final shift.
                        result_r    <= {a_nxt[WIDTH-2:0], q_nxt};
                        res_valid_r <= 1'b1;
                        state       <= StDone;
                    end
                end
                StDone: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        opn_ready_r <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.result    = result_r;
    assign bus.res_valid = res_valid_r;
    assign bus.opn_ready = opn_ready_r;

endmodule

// File: doc/radix2_mul.md
# radix2_mul

Sequential radix-2 Booth multiplier, the multiplicative counterpart of the team's radix-2 divider in the same arithmetic unit. It accepts one signed or unsigned WIDTH×WIDTH operation through a valid/ready handshake and retires one Booth step per clock. It returns a 2·WIDTH-bit product through a second valid/ready handshake that supports backpressure. The divider and multiplier share the arithmetic-unit issue port, so the operand-side signal names and meanings match.

## Interface
- WIDTH, 8: operand width; the product is 2·WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- sign  in  1  1 = operands are two's complement, 0 = operands are unsigned; sampled on accept.
- multiplicand  in  WIDTH  first operand; sampled on accept.
- multiplier  in  WIDTH  second operand; sampled on accept.
- opn_valid  in  1  an operation is offered.
- opn_ready  out  1  the block can accept an operation; high only in IDLE.
- res_valid  out  1  `result` holds a finished product.
- res_ready  in  1  the consumer takes the result.
- result  out  2·WIDTH  product, held stable while res_valid is high.

## Operation
- FSM states IDLE, CALC, DONE.
- **IDLE**
  - opn_ready=1.
  - An accept happens when opn_valid && opn_ready at an edge.
  - On accept, extend both operands to WIDTH+1 bits: sign-extend if sign=1, zero-extend if sign=0.
  - Load M ← extended multiplicand, Q ← extended multiplier, A ← 0 (WIDTH+2 bits), q_m1 ← 0, cnt ← 0.
  - Go to CALC.
- **CALC**, one Booth step per edge:
  - {Q[0], q_m1} = 01: A ← A + M (M sign-extended to WIDTH+2 bits).
  - {Q[0], q_m1} = 10: A ← A − M.
  - 00 and 11: A unchanged.
  - Then arithmetic-shift {A, Q, q_m1} right by 1.
  - cnt increments each step. After step WIDTH+1 (cnt == WIDTH), load result ← low 2·WIDTH bits of {A, Q} after that final shift, set res_valid=1, and go to DONE.
- **DONE**
  - result and res_valid are held.
  - opn_valid is ignored.
  - On res_valid && res_ready at an edge: res_valid ← 0, go to IDLE.
- **Width rules**
  - A is WIDTH+2 bits, so ±M never overflows, including the signed −2^(WIDTH−1) operand.
  - result is exact for both modes; no saturation, no overflow flag.
- **Reset**
  - Any state returns to IDLE. res_valid=0, result=0, opn_ready=1 after reset release.
  - An in-flight operation is discarded and no result is produced.
- **Simultaneous events**
  - opn_valid in CALC or DONE is not accepted; the producer must hold it.
  - The result handshake and a new accept can never coincide because opn_ready=0 in DONE, so the minimum issue interval is WIDTH+3 cycles.

## Timing
- Reset values: opn_ready=1, res_valid=0, result=0.
- Latency: accept at edge E0. Steps execute at E1..E(WIDTH+1). res_valid is high after E(WIDTH+1), i.e. WIDTH+1 cycles after accept (9 for WIDTH=8).
- opn_ready falls after E0 and rises after the edge that completes the result handshake.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package radix2_pkg:
  - FSM state enum (IDLE, CALC, DONE).
  - Default WIDTH constant.
  - Booth-code localparams (ADD=2'b01, SUB=2'b10).
  - Shared with radix2_div so the arithmetic unit uses one state type.
- Sub-module booth_step: combinational, parameterised by WIDTH. Takes {A, Q, q_m1} and M; returns the next {A, Q, q_m1}. The top level is the FSM, counter and handshake registers around one instance.

## Test plan
- Unsigned: sign=0, 0xFF × 0xFF → result=0xFE01, res_valid exactly 9 cycles after accept.
- Signed extreme: sign=1, 0x80 × 0x80 (−128 × −128) → 0x4000. Also 0x80 × 0x7F → 0xC080.
- Mode difference: 0x80 × 0x02 → 0x0100 with sign=0, 0xFF00 with sign=1. 0xFF × 0x01 with sign=1 → 0xFFFF.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid → result stable, opn_ready=0, a new opn_valid is not accepted. Raise res_ready → res_valid drops next edge, opn_ready=1.
- Reset mid-CALC: assert rst at step 4 → res_valid=0, result=0, opn_ready=1. The next operation 3 × 5 → 0x000F with correct latency.
- Back-to-back: hold opn_valid high with res_ready=1 tied → one accept every 11 cycles; every product matches the reference model over 1000 random operations in both modes.
